axi_rd_sram: RTL and testbench
==============================

Name: axi_rd_sram

Overview:
- AXI-style read slave sitting directly downstream of mem_read; answers its AR/R handshakes from on-chip storage.
- Replaces the combinational DPI memory model with a cycle-accurate responder that has configurable latency and INCR bursts.
- A side write port, driven by the store path, updates the storage. The block owns the simulated physical memory for the NPC.

Parameters:
- BASE, 32'h8000_0000, byte address of memory word 0.
- DEPTH_LOG2, 12, log2 of the number of 64-bit words.
- LATENCY, 2, cycles from AR handshake to first RVALID (0 allowed; 0 means RVALID in the cycle after the handshake).

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ARVALID  in  1  read request valid.
- ARREADY  out  1  request accepted when ARVALID && ARREADY.
- ARADDR  in  32  byte address; bits [2:0] ignored (8-byte aligned).
- ARLEN  in  8  burst beats minus 1.
- ARPROT  in  3  accepted, ignored.
- RVALID  out  1  read beat valid.
- RREADY  in  1  master accepts beat.
- RDATA  out  64  beat data.
- RRESP  out  2  2'b00 OKAY, 2'b11 DECERR.
- RLAST  out  1  final beat of the burst.
- wen  in  1  side-port write enable.
- waddr  in  32  side-port byte address; bits [2:0] ignored.
- wdata  in  64  side-port write data.
- wstrb  in  8  byte enables; bit i writes byte i.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While ARESET is high at a clock edge: state←IDLE, RVALID=0, RLAST=0, RDATA=0, RRESP=0. ARREADY=0 during any cycle with ARESET high. Memory contents are not cleared.
- Reset during WAIT or BEAT aborts the burst; no further beats are produced.
- FSM states: IDLE, WAIT, BEAT.
  - IDLE: ARREADY=1, RVALID=0. On an AR handshake:
    - latch idx=(ARADDR-BASE)>>3 truncated to DEPTH_LOG2 bits, len=ARLEN, beat=0, err=(ARADDR<BASE || ARADDR>=BASE+8·2^DEPTH_LOG2).
    - if LATENCY==0, go to BEAT; else cnt←LATENCY and go to WAIT.
  - WAIT: ARREADY=0. cnt decrements each cycle; the cycle cnt==1 transitions to BEAT. The first RVALID appears exactly LATENCY+1 cycles after the handshake edge.
  - BEAT: RVALID=1, ARREADY=0.
    - RDATA is registered: mem[idx] is loaded on BEAT entry and after each beat handshake.
    - RRESP=err?DECERR:OKAY. If err, RDATA=0.
    - RLAST=(beat==len).
    - RDATA, RRESP and RLAST are held stable while RVALID && !RREADY.
    - On RVALID&&RREADY: if RLAST, go to IDLE (ARREADY high the next cycle). Else beat+1, idx+1 modulo 2^DEPTH_LOG2 (wrap, still OKAY if the start was in range), and stay in BEAT with no bubble.
- No outstanding-request queue: a single burst is in flight at a time.
- Side write: at a rising edge with wen and waddr in range, write the strobed bytes of mem[(waddr-BASE)>>3]. Out-of-range writes are dropped silently.
- Same-cycle write and read-load of the same index: the load gets the old data (read-before-write). A beat already presented is never altered by a later write.
- Address arithmetic is 32-bit unsigned. The index is sliced after subtraction.

Decomposition:
- Package axi_rd_pkg holds:
  - RRESP_OKAY=2'b00, RRESP_DECERR=2'b11;
  - the state enum {IDLE, WAIT, BEAT};
  - DATA_W=64, ADDR_W=32.
- Sub-module sram_1r1w (DEPTH_LOG2, 64-bit): synchronous read port (registered, read-before-write) and byte-strobed write port. The top holds the FSM, counters and response logic.

Test Plan:
- Preload mem[0]=64'h1122334455667788 via the side port, LATENCY=2. AR ARADDR=32'h8000_0000, ARLEN=0, RREADY=1 → RVALID rises 3 cycles after the handshake; RDATA=64'h1122334455667788, RLAST=1, RRESP=0; ARREADY=1 the next cycle.
- Burst ARLEN=3 at 32'h8000_0008 with mem[1..4]=1,2,3,4, RREADY toggling 1,0,1,0… → beats 1,2,3,4 in order; data is stable during stalls; RLAST only on beat 4.
- ARADDR=32'h7FFF_FFF8, ARLEN=1 → two beats, RRESP=2'b11, RDATA=0, RLAST on the second beat.
- Start at the last word (BASE+8·4095), ARLEN=1 → beat 2 returns mem[0] with OKAY (wrap-around).
- wen with wstrb=8'h0F, wdata=64'hFFFF_FFFF_FFFF_FFFF to a word holding 0, issued the same cycle as that word's read-load → the read returns 0; a subsequent read returns 64'h0000_0000_FFFF_FFFF.
- ARESET high for one cycle mid-burst (after beat 1 of 4) → RVALID=0 next cycle, no further beats; ARREADY=1 after reset is released; the memory keeps its contents.

Source files
------------

// File: rtl/axi_rd_sram_pkg.sv
// rtl/axi_rd_sram_pkg.sv - shared types, widths and response codes for the SRAM read responder
package axi_rd_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT
  } state_e;

  // True when an 8-byte-aligned address falls inside the window of 2^dl2 words at base.
  function automatic logic in_window(input logic [ADDR_W-1:0] aligned,
                                     input logic [ADDR_W-1:0] base,
                                     input int                dl2);
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] size;
    off  = aligned - base;
    size = 32'd8 << dl2;
    return (aligned >= base) && (off < size);
  endfunction

endpackage

// File: rtl/axi_rd_sram_if.sv
// rtl/axi_rd_sram_if.sv - AR/R read channel bundle between mem_read and the SRAM responder
interface axi_rd_sram_if;
  import axi_rd_pkg::*;

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARPROT;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARPROT, RREADY,
    input  ARREADY, RVALID, RDATA, RRESP, RLAST
  );

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARPROT, RREADY,
    output ARREADY, RVALID, RDATA, RRESP, RLAST
  );

endinterface

// File: rtl/axi_rd_sram_sram_1r1w.sv
// rtl/axi_rd_sram_sram_1r1w.sv - 64-bit word memory, registered read port, byte-strobed write port
module sram_1r1w
  import axi_rd_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Byte-strobed write; a read of the same word in the same cycle sees the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axi_rd_sram.sv
// rtl/axi_rd_sram.sv - cycle-accurate AXI-style read slave over on-chip SRAM with side write port
module axi_rd_sram
  import axi_rd_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE       = 32'h8000_0000,
  parameter int                DEPTH_LOG2 = 12,
  parameter int                LATENCY    = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  axi_rd_sram_if.slave        bus,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb
);

  localparam int CNT_W = $clog2(LATENCY + 2);

  state_e                state;
  logic [DEPTH_LOG2-1:0] idx;
  logic [7:0]            len;
  logic [7:0]            beat;
  logic                  err;
  logic [CNT_W-1:0]      cnt;
  logic                  rvalid_q;

  logic [ADDR_W-1:0]     ar_aligned;
  logic [ADDR_W-1:0]     ar_off;
  logic [ADDR_W-1:0]     w_aligned;
  logic [ADDR_W-1:0]     w_off;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  last;
  logic                  rd_en;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic                  wr_en;

  assign ar_aligned = {bus.ARADDR[ADDR_W-1:3], 3'b000};
  assign ar_off     = ar_aligned - BASE;
  assign w_aligned  = {waddr[ADDR_W-1:3], 3'b000};
  assign w_off      = w_aligned - BASE;

  assign ar_fire = bus.ARVALID && bus.ARREADY;
  assign r_fire  = rvalid_q && bus.RREADY;
  assign last    = (beat == len);

  // BEAT opens with one load cycle (rvalid_q low) that fetches the first word;
  // afterwards each accepted non-final beat prefetches the next word so beats run back to back.
  assign rd_en   = ((state == BEAT) && !rvalid_q) || (r_fire && !last);
  assign rd_addr = rvalid_q ? idx + 1'b1 : idx;
  assign wr_en   = wen && in_window(w_aligned, BASE, DEPTH_LOG2);

  sram_1r1w #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clk     (ACLK),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (w_off[3 +: DEPTH_LOG2]),
    .wr_data (wdata),
    .wr_strb (wstrb)
  );

  // Burst sequencing: accept a request, count down the latency, then stream beats.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      rvalid_q <= 1'b0;
      idx      <= '0;
      len      <= '0;
      beat     <= '0;
      err      <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          rvalid_q <= 1'b0;
          if (ar_fire) begin
            idx  <= ar_off[3 +: DEPTH_LOG2];
            len  <= bus.ARLEN;
            beat <= '0;
            err  <= !in_window(ar_aligned, BASE, DEPTH_LOG2);
            if (LATENCY == 0) begin
              state <= BEAT;
            end else begin
              cnt   <= CNT_W'(LATENCY);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= BEAT;
          end
        end
        BEAT: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
          end else if (r_fire) begin
            if (last) begin
              rvalid_q <= 1'b0;
              state    <= IDLE;
            end else begin
              beat <= beat + 8'd1;
              idx  <= idx + 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ARREADY = (state == IDLE) && !ARESET;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = (rvalid_q && !err) ? rd_data : '0;
  assign bus.RRESP   = (rvalid_q && err) ? RRESP_DECERR : RRESP_OKAY;
  assign bus.RLAST   = rvalid_q && last;

  logic unused_bits;
  assign unused_bits = ^{bus.ARPROT, bus.ARADDR[2:0], waddr[2:0],
                         ar_off[2:0], ar_off[ADDR_W-1:3+DEPTH_LOG2],
                         w_off[2:0], w_off[ADDR_W-1:3+DEPTH_LOG2]};

endmodule

// File: tb/tb_axi_rd_sram.sv
// tb/tb_axi_rd_sram.sv - self-checking bench for axi_rd_sram
module tb_axi_rd_sram;
  import axi_rd_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          DL2  = 12;
  localparam int          LAT  = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        toggle;
    logic [1:0]  exp_resp;
  } vec_t;

  logic        ACLK   = 1'b0;
  logic        ARESET = 1'b1;
  logic        wen    = 1'b0;
  logic [31:0] waddr  = '0;
  logic [63:0] wdata  = '0;
  logic [7:0]  wstrb  = '0;

  axi_rd_sram_if bus();

  axi_rd_sram #(.BASE(BASE), .DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus),
    .wen    (wen),
    .waddr  (waddr),
    .wdata  (wdata),
    .wstrb  (wstrb)
  );

  always #5 ACLK = ~ACLK;

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          rr_mode = 0;
  beat_t       sb[$];
  logic [63:0] ref_mem [0:4095];
  vec_t        vecs [7];

  logic        pv   = 1'b0;
  logic        pr   = 1'b0;
  logic        prst = 1'b1;
  logic [66:0] pbeat = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] aa;
    aa = {a[31:3], 3'b000};
    return (aa >= 32'h8000_0000) && (aa < 32'h8000_8000);
  endfunction

  function automatic logic [11:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = {a[31:3], 3'b000} - BASE;
    return off[14:3];
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [11:0] w;
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(posedge ACLK); #1;
    wen = 1'b0;
    if (in_rng(a)) begin
      w = word_of(a);
      for (int i = 0; i < 8; i++) if (s[i]) ref_mem[w][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] l);
    logic got;
    got = 1'b0;
    bus.ARADDR = a; bus.ARLEN = l; bus.ARPROT = 3'b010; bus.ARVALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      got = bus.ARREADY;
      @(posedge ACLK); #1;
      if (got) break;
    end
    bus.ARVALID = 1'b0;
    if (!got) timeout("ar_handshake");
  endtask

  task automatic push_beat(input logic [63:0] d, input logic [1:0] r, input logic l);
    beat_t b;
    b.data = d; b.resp = r; b.last = l;
    sb.push_back(b);
  endtask

  task automatic push_burst(input logic [31:0] a, input logic [7:0] l, input logic [1:0] r);
    logic [11:0] w;
    w = word_of(a);
    for (int b = 0; b <= int'(l); b++) begin
      push_beat((r == 2'b11) ? 64'h0 : ref_mem[w], r, b == int'(l));
      w = w + 12'd1;
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (sb.size() == 0 && bus.ARREADY && !bus.RVALID) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout(name);
      sb.delete();
    end
    @(posedge ACLK); #1;
  endtask

  // RREADY pattern: 0 = always high, 1 = toggle every cycle, 2 = left to the test.
  initial begin
    bus.RREADY = 1'b1;
    forever begin
      @(posedge ACLK); #1;
      if (rr_mode == 0) bus.RREADY = 1'b1;
      else if (rr_mode == 1) bus.RREADY = ~bus.RREADY;
    end
  end

  // Beat monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    beat_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESET && !prst && pv && !pr)
        check("stall_hold", 128'({bus.RVALID, bus.RDATA, bus.RRESP, bus.RLAST}), 128'({1'b1, pbeat}));
      if (!ARESET && bus.RVALID && bus.RREADY) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %0h resp %0h, want no beat", bus.RDATA, bus.RRESP);
        end else begin
          e = sb.pop_front();
          check("beat", 128'({bus.RDATA, bus.RRESP, bus.RLAST}), 128'({e.data, e.resp, e.last}));
        end
      end
      pv    = bus.RVALID;
      pr    = bus.RREADY;
      prst  = ARESET;
      pbeat = {bus.RDATA, bus.RRESP, bus.RLAST};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int highs;

    bus.ARVALID = 1'b0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARPROT = '0;

    vecs[0] = '{addr: 32'h8000_0000, len: 8'd0, toggle: 1'b0, exp_resp: 2'b00};
    vecs[1] = '{addr: 32'h8000_0008, len: 8'd3, toggle: 1'b1, exp_resp: 2'b00};
    vecs[2] = '{addr: 32'h7FFF_FFF8, len: 8'd1, toggle: 1'b0, exp_resp: 2'b11};
    vecs[3] = '{addr: 32'h8000_7FF8, len: 8'd1, toggle: 1'b0, exp_resp: 2'b00};
    vecs[4] = '{addr: 32'h8000_8000, len: 8'd0, toggle: 1'b1, exp_resp: 2'b11};
    vecs[5] = '{addr: 32'h8000_0013, len: 8'd2, toggle: 1'b1, exp_resp: 2'b00};
    vecs[6] = '{addr: 32'h8000_0010, len: 8'd7, toggle: 1'b0, exp_resp: 2'b00};

    // Reset state
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check("rst_arready", 128'(bus.ARREADY), 128'(0));
    check("rst_rvalid",  128'(bus.RVALID),  128'(0));
    check("rst_rdata",   128'(bus.RDATA),   128'(0));
    check("rst_rresp",   128'(bus.RRESP),   128'(0));
    check("rst_rlast",   128'(bus.RLAST),   128'(0));
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Preload through the side port
    mem_write(32'h8000_0000, 64'h1122_3344_5566_7788, 8'hFF);
    mem_write(32'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    for (int i = 1; i <= 4; i++) mem_write(BASE + 32'(8*i), 64'(i), 8'hFF);
    for (int i = 5; i <= 9; i++) mem_write(BASE + 32'(8*i), {32'hC0DE_0000, 32'(i)}, 8'hFF);
    mem_write(32'h8000_0028, 64'hAAAA_AAAA_BBBB_BBBB, 8'hF0);
    mem_write(32'h8000_0050, 64'h0, 8'hFF);
    mem_write(32'h8000_7FF8, 64'hDEAD_BEEF_0000_0FFF, 8'hFF);

    // First-beat latency and ARREADY return after a single-beat burst
    rr_mode = 0;
    issue_ar(32'h8000_0000, 8'd0);
    push_beat(64'h1122_3344_5566_7788, 2'b00, 1'b1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.RVALID) break;
      k++;
    end
    check("first_rvalid_latency", 128'(k), 128'(LAT + 1));
    @(negedge ACLK);
    check("arready_after_last", 128'({bus.ARREADY, bus.RVALID}), 128'(2'b10));
    wait_idle("latency_idle");

    // Table of bursts checked through the scoreboard
    for (int v = 0; v < 7; v++) begin
      rr_mode = vecs[v].toggle ? 1 : 0;
      issue_ar(vecs[v].addr, vecs[v].len);
      push_burst(vecs[v].addr, vecs[v].len, vecs[v].exp_resp);
      wait_idle("vector_idle");
    end
    rr_mode = 0;

    // Side write landing on the same edge as the read-load of that word
    issue_ar(32'h8000_0050, 8'd0);
    push_beat(64'h0, 2'b00, 1'b1);
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    wen = 1'b1; waddr = 32'h8000_0050; wdata = 64'hFFFF_FFFF_FFFF_FFFF; wstrb = 8'h0F;
    @(posedge ACLK); #1;
    wen = 1'b0;
    ref_mem[10] = 64'h0000_0000_FFFF_FFFF;
    wait_idle("rbw_idle");
    issue_ar(32'h8000_0050, 8'd0);
    push_beat(64'h0000_0000_FFFF_FFFF, 2'b00, 1'b1);
    wait_idle("rbw_reread_idle");

    // Reset after the first beat of a four-beat burst
    rr_mode = 2;
    bus.RREADY = 1'b1;
    issue_ar(32'h8000_0008, 8'd3);
    push_beat(64'h1, 2'b00, 1'b0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      if (bus.RVALID) break;
      k++;
    end
    @(posedge ACLK); #1;
    bus.RREADY = 1'b0;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    bus.RREADY = 1'b1;
    @(negedge ACLK);
    check("rvalid_after_reset",  128'(bus.RVALID),  128'(0));
    check("arready_after_reset", 128'(bus.ARREADY), 128'(1));
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (bus.RVALID) highs++;
    end
    check("no_beats_after_reset", 128'(highs), 128'(0));
    check("abort_sb_drained", 128'(sb.size()), 128'(0));
    sb.delete();
    @(posedge ACLK); #1;
    rr_mode = 0;
    issue_ar(32'h8000_0008, 8'd1);
    push_beat(64'h1, 2'b00, 1'b0);
    push_beat(64'h2, 2'b00, 1'b1);
    wait_idle("post_reset_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
